rng_scheduler: RTL and testbench
================================

RNG_SCHEDULER -- requirements
Module: rng_scheduler

Interface
REQ-001 Parameter: NREQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter: RST_SEED, 16'hACE1, LFSR value after reset and substitute for an all-zero seed.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seed_load  input  1  level-sampled request to load seed into the LFSR.
REQ-006 seed  input  16  seed value, sampled when seed_load=1.
REQ-007 req  input  4  per-requester random-number request; requester holds high until its gnt bit is seen.
REQ-008 gnt  output  4  registered one-hot grant; high for exactly one cycle per served request.
REQ-009 rnd  output  16  registered random word delivered with the grant.
REQ-010 rnd_valid  output  1  high in the same cycle as any gnt bit.
REQ-011 rnd_id  output  2  index of the granted requester, valid when rnd_valid=1.
REQ-012 wrap  output  1  one-cycle pulse when the LFSR completes a full period since the last seed load or reset.
REQ-013 busy  output  1  high while the FSM is in SEED.

Function
REQ-014 LFSR: 16-bit Fibonacci, one step = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, maximal period 65535.
REQ-015 LFSR advances exactly one step on every clock edge in IDLE and GRANT; it holds in SEED.
REQ-016 FSM states: IDLE (no grant this cycle), GRANT (grant issued), SEED (load cycle).
REQ-017 seed_load=1 at an edge, in any state: next state SEED; lfsr <= seed, or RST_SEED if seed==0; step counter <= 0; gnt <= 0; rnd_valid <= 0.
REQ-018 SEED lasts exactly one cycle, then goes to IDLE; busy=1 only in SEED.
REQ-019 Not seed_load, not in SEED, req!=0: next state GRANT; winner is the first set req bit scanning upward, modulo 4, from ptr+1.
REQ-020 On a grant: gnt <= one-hot(winner); rnd <= current lfsr (pre-advance value); rnd_id <= winner; rnd_valid <= 1; ptr <= winner.
REQ-021 Not seed_load and req==0: next state IDLE; gnt, rnd_valid <= 0; rnd and rnd_id hold their last values.
REQ-022 Throughput: one grant per cycle maximum. Back-to-back grants are allowed, each delivering a distinct consecutive LFSR value.
REQ-023 Fairness: with all req held, each requester is granted exactly once in every 4 consecutive grant cycles.
REQ-024 A requester whose req is still high on the edge after its gnt is treated as a new request and competes round-robin.
REQ-025 seed_load together with req!=0: the seed load wins; no grant that cycle; requests are served from the cycle after SEED.
REQ-026 seed_load held high for several cycles: the seed reloads every cycle, the FSM stays in SEED, and no grants are issued.
REQ-027 Step counter: 16 bits, increments with each LFSR advance. On the advance from 65534 it wraps to 0 and wrap <= 1 for one cycle; at that point lfsr equals the loaded seed.
REQ-028 lfsr never holds 0. If it ever reads 0, the next edge loads RST_SEED.

Reset
REQ-029 On rst_n=0, immediately and independent of clk: lfsr=RST_SEED, state=IDLE, ptr=3, step counter=0, gnt=0, rnd=0, rnd_id=0, rnd_valid=0, wrap=0, busy=0.
REQ-030 Reset mid-grant or mid-SEED discards the operation in progress; the first edge after release behaves as IDLE with lfsr=16'hACE1.

Verification
REQ-031 Reset, then req=4'b0001 at the first edge -> gnt=0001, rnd=16'hACE1, rnd_id=0, rnd_valid=1. req held one more edge -> rnd=16'h59C3.
REQ-032 req=4'b1111 held for 8 edges after reset -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rnd takes 8 consecutive LFSR values.
REQ-033 seed_load=1 with seed=16'h0000 -> busy=1 for one cycle, gnt=0, lfsr=16'hACE1. seed=16'h1234 -> the next grant delivers rnd=16'h1234.
REQ-034 seed_load and req=4'b0100 on the same edge -> no grant that cycle; gnt=0100 two edges later with rnd=loaded seed.
REQ-035 Load seed 16'h0001, then run 65535 free cycles -> wrap pulses exactly once, one cycle wide, with lfsr=16'h0001.
REQ-036 Assert rst_n=0 asynchronously between edges during a 4-way grant burst -> all outputs reach REQ-029 values before the next edge; after release, round-robin restarts at requester 0.

Source files
------------

// File: rtl/rng_scheduler.sv
// Round-robin scheduler that hands out 16-bit Fibonacci LFSR words to up to
// four requesters, with seed loading and a full-period wrap indicator.
module rng_scheduler #(
  parameter int          NREQ     = 4,
  parameter logic [15:0] RST_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     seed_load_i,
  input  logic [15:0]              seed_i,
  input  logic [NREQ-1:0]          req_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [15:0]              rnd_o,
  output logic                     rnd_valid_o,
  output logic [$clog2(NREQ)-1:0]  rnd_id_o,
  output logic                     wrap_o,
  output logic                     busy_o
);

  // state | meaning
  // IDLE  | no grant issued this cycle, LFSR free-running
  // GRANT | grant issued this cycle, LFSR free-running
  // SEED  | seed load cycle, LFSR held
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEED  = 2'd2
  } state_e;

  localparam int IDW = $clog2(NREQ);

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [15:0]        rnd_q, rnd_d;
  logic [IDW-1:0]     rnd_id_q, rnd_id_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic               wrap_q, wrap_d;

  logic               found;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     idx;
  logic [15:0]        lfsr_step;

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Round-robin search starting just after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ptr_q + IDW'(i);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (seed_load_i)            state_d = SEED;
    else if (state_q == SEED)   state_d = IDLE;
    else if (req_i != '0)       state_d = GRANT;
    else                        state_d = IDLE;
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rnd_d       = rnd_q;
    rnd_id_d    = rnd_id_q;
    rnd_valid_d = 1'b0;
    wrap_d      = 1'b0;

    if (seed_load_i) begin
      lfsr_d = (seed_i == 16'h0000) ? RST_SEED : seed_i;
      cnt_d  = '0;
    end else if (state_q != SEED) begin
      // A zero LFSR would lock up; recover to the reset seed.
      lfsr_d = (lfsr_q == 16'h0000) ? RST_SEED : lfsr_step;
      if (cnt_q == 16'hFFFE) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      if (found) begin
        gnt_d         = '0;
        gnt_d[winner] = 1'b1;
        rnd_d         = lfsr_q;
        rnd_id_d      = winner;
        rnd_valid_d   = 1'b1;
        ptr_d         = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= RST_SEED;
      cnt_q       <= '0;
      ptr_q       <= IDW'(NREQ - 1);
      gnt_q       <= '0;
      rnd_q       <= '0;
      rnd_id_q    <= '0;
      rnd_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rnd_q       <= rnd_d;
      rnd_id_q    <= rnd_id_d;
      rnd_valid_q <= rnd_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rnd_o       = rnd_q;
  assign rnd_id_o    = rnd_id_q;
  assign rnd_valid_o = rnd_valid_q;
  assign wrap_o      = wrap_q;
  assign busy_o      = (state_q == SEED);

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed bench for rng_scheduler: reset, grants, round-robin, seeding,
// async reset mid-burst and full-period wrap.
module tb_rng_scheduler;

  logic        clk;
  logic        rst_n;
  logic        seed_load_i;
  logic [15:0] seed_i;
  logic [3:0]  req_i;
  logic [3:0]  gnt_o;
  logic [15:0] rnd_o;
  logic        rnd_valid_o;
  logic [1:0]  rnd_id_o;
  logic        wrap_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  rng_scheduler #(.NREQ(4), .RST_SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rnd_o       (rnd_o),
    .rnd_valid_o (rnd_valid_o),
    .rnd_id_o    (rnd_id_o),
    .wrap_o      (wrap_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".gnt"},   32'(gnt_o),       32'h0);
    chk({tag, ".rnd"},   32'(rnd_o),       32'h0);
    chk({tag, ".id"},    32'(rnd_id_o),    32'h0);
    chk({tag, ".valid"}, 32'(rnd_valid_o), 32'h0);
    chk({tag, ".wrap"},  32'(wrap_o),      32'h0);
    chk({tag, ".busy"},  32'(busy_o),      32'h0);
  endtask

  logic [15:0] lfsr_seq [0:7];
  logic [3:0]  rr_seq   [0:7];
  int          wraps;
  int          wrap_at;

  initial begin
    lfsr_seq[0] = 16'hACE1; lfsr_seq[1] = 16'h59C3; lfsr_seq[2] = 16'hB387; lfsr_seq[3] = 16'h670F;
    lfsr_seq[4] = 16'hCE1E; lfsr_seq[5] = 16'h9C3C; lfsr_seq[6] = 16'h3879; lfsr_seq[7] = 16'h70F2;
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100; rr_seq[3] = 4'b1000;
    rr_seq[4] = 4'b0001; rr_seq[5] = 4'b0010; rr_seq[6] = 4'b0100; rr_seq[7] = 4'b1000;

    rst_n       = 1'b0;
    seed_load_i = 1'b0;
    seed_i      = 16'h0000;
    req_i       = 4'b0000;
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // single requester, held for a second edge
    req_i = 4'b0001;
    tick();
    chk("g1.gnt",   32'(gnt_o),       32'h1);
    chk("g1.rnd",   32'(rnd_o),       32'hACE1);
    chk("g1.id",    32'(rnd_id_o),    32'h0);
    chk("g1.valid", 32'(rnd_valid_o), 32'h1);
    tick();
    chk("g2.gnt",   32'(gnt_o),       32'h1);
    chk("g2.rnd",   32'(rnd_o),       32'h59C3);
    req_i = 4'b0000;
    tick();
    chk("idle.gnt",   32'(gnt_o),       32'h0);
    chk("idle.valid", 32'(rnd_valid_o), 32'h0);
    chk("idle.rnd",   32'(rnd_o),       32'h59C3);
    chk("idle.id",    32'(rnd_id_o),    32'h0);

    // four-way round robin from a fresh reset
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr%0d.gnt", k), 32'(gnt_o),    32'(rr_seq[k]));
      chk($sformatf("rr%0d.rnd", k), 32'(rnd_o),    32'(lfsr_seq[k]));
      chk($sformatf("rr%0d.id", k),  32'(rnd_id_o), 32'(k % 4));
    end

    // async reset mid-burst
    tick();
    tick();
    chk("burst.gnt", 32'(gnt_o), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst.gnt", 32'(gnt_o), 32'h1);
    chk("post_rst.rnd", 32'(rnd_o), 32'hACE1);
    req_i = 4'b0000;

    // zero seed substitutes the reset seed
    seed_load_i = 1'b1;
    seed_i      = 16'h0000;
    tick();
    chk("seed0.busy",  32'(busy_o),      32'h1);
    chk("seed0.gnt",   32'(gnt_o),       32'h0);
    chk("seed0.valid", 32'(rnd_valid_o), 32'h0);
    seed_load_i = 1'b0;
    req_i       = 4'b0010;
    tick();
    chk("seed0_exit.busy", 32'(busy_o), 32'h0);
    chk("seed0_exit.gnt",  32'(gnt_o),  32'h0);
    tick();
    chk("seed0_g.gnt", 32'(gnt_o),    32'h2);
    chk("seed0_g.rnd", 32'(rnd_o),    32'hACE1);
    chk("seed0_g.id",  32'(rnd_id_o), 32'h1);
    req_i = 4'b0000;

    // seed load wins over a simultaneous request
    seed_load_i = 1'b1;
    seed_i      = 16'h1234;
    req_i       = 4'b0100;
    tick();
    chk("seedreq.gnt",  32'(gnt_o),  32'h0);
    chk("seedreq.busy", 32'(busy_o), 32'h1);
    seed_load_i = 1'b0;
    tick();
    chk("seedreq2.gnt",  32'(gnt_o),  32'h0);
    chk("seedreq2.busy", 32'(busy_o), 32'h0);
    tick();
    chk("seedreq3.gnt", 32'(gnt_o),    32'h4);
    chk("seedreq3.rnd", 32'(rnd_o),    32'h1234);
    chk("seedreq3.id",  32'(rnd_id_o), 32'h2);
    tick();
    chk("seedreq4.gnt", 32'(gnt_o), 32'h4);
    chk("seedreq4.rnd", 32'(rnd_o), 32'h2469);
    req_i = 4'b0000;
    tick();
    chk("hold.rnd", 32'(rnd_o),    32'h2469);
    chk("hold.id",  32'(rnd_id_o), 32'h2);

    // seed_load held for several cycles with all requests pending
    seed_load_i = 1'b1;
    req_i       = 4'b1111;
    seed_i      = 16'h1111;
    tick();
    chk("hseed1.busy", 32'(busy_o), 32'h1);
    chk("hseed1.gnt",  32'(gnt_o),  32'h0);
    seed_i = 16'h2222;
    tick();
    chk("hseed2.busy", 32'(busy_o), 32'h1);
    chk("hseed2.gnt",  32'(gnt_o),  32'h0);
    seed_i = 16'hBEEF;
    tick();
    chk("hseed3.busy", 32'(busy_o), 32'h1);
    chk("hseed3.gnt",  32'(gnt_o),  32'h0);
    seed_load_i = 1'b0;
    tick();
    chk("hseed4.busy", 32'(busy_o), 32'h0);
    chk("hseed4.gnt",  32'(gnt_o),  32'h0);
    tick();
    chk("hseed5.gnt", 32'(gnt_o),    32'h8);
    chk("hseed5.rnd", 32'(rnd_o),    32'hBEEF);
    chk("hseed5.id",  32'(rnd_id_o), 32'h3);
    req_i = 4'b0000;

    // full-period wrap from seed 0001
    seed_load_i = 1'b1;
    seed_i      = 16'h0001;
    tick();
    seed_load_i = 1'b0;
    wraps   = 0;
    wrap_at = -1;
    for (int i = 1; i <= 65536; i++) begin
      tick();
      if (wrap_o === 1'b1) begin
        wraps++;
        wrap_at = i;
      end
    end
    chk("wrap.count", 32'(wraps),   32'd1);
    chk("wrap.at",    32'(wrap_at), 32'd65536);
    req_i = 4'b0001;
    tick();
    chk("wrap.width", 32'(wrap_o), 32'h0);
    chk("wrap.gnt",   32'(gnt_o),  32'h1);
    chk("wrap.lfsr",  32'(rnd_o),  32'h0001);
    req_i = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
